// File: rtl/tile_config_loader.sv
// Fabric configuration sequencer: buffers host commands in a FIFO and expands
// each into held single-tile writes on the shared config bus, parking it at 0 between commands.
module tile_config_loader #(
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    input  logic [15:0] in_count,
    output logic [31:0] config_addr,
    output logic [31:0] config_data,
    output logic        busy,
    output logic [31:0] words_written
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [15:0] count;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} state_t;

    cmd_t          r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [PW:0]   r_level;
    logic          r_full;

    state_t        r_state;
    logic [31:0]   r_addr, r_data, r_words;
    logic [15:0]   r_remaining;
    logic [HW-1:0] r_hold;

    logic          w_push, w_pop, w_empty, w_hold_last;
    logic [PW:0]   w_level_nxt;
    cmd_t          w_head;
    logic [15:0]   w_head_cnt;

    assign w_empty     = (r_level == '0);
    assign in_ready    = reset && !r_full;
    assign w_push      = in_valid && in_ready;
    assign w_pop       = ((r_state == S_IDLE) || (r_state == S_GAP)) && !w_empty;
    assign w_level_nxt = r_level + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_cnt  = (w_head.count == 16'd0) ? 16'd1 : w_head.count;
    assign w_hold_last = (r_hold == HW'(HOLD_CYCLES - 1));

    // Storage carries no reset; the level counter alone defines validity.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= '{addr: in_addr, data: in_data, count: in_count};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == (PW+1)'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_data      <= '0;
            r_words     <= '0;
            r_remaining <= '0;
            r_hold      <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_GAP: begin
                    // Bus is already parked at 0 on entry to either state.
                    if (w_pop) begin
                        r_addr      <= w_head.addr;
                        r_data      <= w_head.data;
                        r_remaining <= w_head_cnt;
                        r_hold      <= '0;
                        r_state     <= S_DRIVE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_DRIVE: begin
                    if (w_hold_last) begin
                        r_words <= r_words + 32'd1;
                        if (r_remaining > 16'd1) begin
                            r_addr[15:0] <= r_addr[15:0] + 16'd1;
                            r_remaining  <= r_remaining - 16'd1;
                            r_hold       <= '0;
                        end else begin
                            r_addr      <= '0;
                            r_data      <= '0;
                            r_remaining <= '0;
                            r_state     <= S_GAP;
                        end
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign config_addr   = r_addr;
    assign config_data   = r_data;
    assign words_written = r_words;
    assign busy          = (r_state != S_IDLE) || !w_empty;
endmodule

// File: tb/tb_tile_config_loader.sv
// Bench for tile_config_loader: directed and random commands checked cycle by cycle
// against a queue model that expands each command into its expected bus trace.
module tb_tile_config_loader;
    localparam int DEPTH = 4;
    localparam int HOLD  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_addr = '0, in_data = '0;
    logic [15:0] in_count = '0;
    logic [31:0] config_addr, config_data, words_written;
    logic        busy;

    tile_config_loader #(.FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .in_count(in_count),
        .config_addr(config_addr), .config_data(config_data),
        .busy(busy), .words_written(words_written)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic        last;
    } bus_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [15:0] c;
    } cmd_t;

    cmd_t        q_cmd[$];
    bus_t        q_bus[$];
    bus_t        cur = '0;
    bit          cur_act = 1'b0;
    bit          m_ready = 1'b1;
    bit          m_acc = 1'b0;
    logic [31:0] m_words = '0;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    // Expected per-cycle bus contents for one command, including its zero gap cycle.
    task automatic expand(input cmd_t c);
        int n;
        bus_t b;
        n = (c.c == 16'd0) ? 1 : int'(c.c);
        for (int t = 0; t < n; t++) begin
            for (int h = 0; h < HOLD; h++) begin
                b.a    = {c.a[31:16], 16'(c.a[15:0] + 16'(t))};
                b.d    = c.d;
                b.last = (h == HOLD - 1);
                q_bus.push_back(b);
            end
        end
        q_bus.push_back('0);
    endtask

    task automatic model_edge();
        if (cur_act && cur.last) m_words++;
        if (q_bus.size() != 0) begin
            cur = q_bus.pop_front(); cur_act = 1'b1;
        end else if (q_cmd.size() != 0) begin
            expand(q_cmd.pop_front());
            cur = q_bus.pop_front(); cur_act = 1'b1;
        end else begin
            cur = '0; cur_act = 1'b0;
        end
        m_acc = in_valid && m_ready;
        if (m_acc) q_cmd.push_back('{a: in_addr, d: in_data, c: in_count});
        m_ready = (q_cmd.size() < DEPTH);
    endtask

    task automatic compare();
        chk("addr", config_addr, cur.a);
        chk("data", config_data, cur.d);
        chk("words", words_written, m_words);
        chk("ready", {31'd0, in_ready}, {31'd0, m_ready});
        chk("busy", {31'd0, busy}, {31'd0, (cur_act || q_cmd.size() != 0)});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [15:0] c);
        int guard;
        in_valid = 1'b1; in_addr = a; in_data = d; in_count = c;
        guard = 0;
        do begin
            step();
            guard++;
        end while (!m_acc && guard < 50);
        if (!m_acc) chk("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_addr"}, config_addr, 32'd0);
        chk({tag, "_data"}, config_data, 32'd0);
        chk({tag, "_words"}, words_written, 32'd0);
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic model_reset();
        q_cmd.delete(); q_bus.delete();
        cur = '0; cur_act = 1'b0; m_words = '0; m_ready = 1'b1; m_acc = 1'b0;
    endtask

    initial begin
        logic [15:0] tid;
        repeat (2) @(negedge clk);
        #1 check_reset_state("reset");
        @(negedge clk);
        reset = 1'b1;

        send(32'h0004_0003, 32'h2, 16'd1);
        idle(6);
        send(32'h0007_FFFE, 32'hA5, 16'd3);
        idle(10);
        chk("burst_words", words_written, 32'd4);
        for (int i = 0; i < 6; i++) send(32'h0005_0010 + 32'(i), 32'(i + 1), 16'd1);
        idle(20);
        send(32'h0004_0020, 32'h77, 16'd0);
        idle(6);
        send(32'h0006_0001, 32'h5, 16'd1);
        send(32'h0006_0001, 32'h5, 16'd1);
        idle(8);

        for (int i = 0; i < 600; i++) begin
            tid = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFF - 16'($urandom_range(0, 2))) : 16'($urandom);
            in_valid = ($urandom_range(0, 1) == 1);
            in_addr  = {16'(4 + $urandom_range(0, 3)), tid};
            in_data  = $urandom;
            in_count = 16'($urandom_range(0, 4));
            step();
        end
        idle(60);

        send(32'h0005_0100, 32'hDEAD_BEEF, 16'd8);
        in_valid = 1'b1; in_addr = 32'h0004_0001; in_data = 32'h1; in_count = 16'd1;
        repeat (2 * HOLD + 1) step();
        in_valid = 1'b0;
        chk("midburst_addr", config_addr, 32'h0005_0102);
        #2 reset = 1'b0;
        #1 check_reset_state("async_rst");
        model_reset();
        @(negedge clk);
        check_reset_state("held_rst");
        reset = 1'b1;
        idle(6);
        send(32'h0007_0042, 32'h99, 16'd2);
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
